// File: rtl/cnn_pkg.sv
// Shared types and default sizes for the CNN datapath.
// The FC operand stream carries one fc_pair_t per transfer.
`timescale 1ns/1ps
package cnn_pkg;

  localparam int ACT_W   = 30;
  localparam int W_W     = 9;
  localparam int N_IN_FC = 3136;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_feed_state_t;

  typedef struct packed {
    logic [ACT_W-1:0] act;
    logic [W_W-1:0]   w;
    logic             last;
  } fc_pair_t;

endpackage

// File: rtl/fc_pair_fifo.sv
// Two-entry pair FIFO with a registered head entry.
// Push and pop may coincide; the caller never pushes into a full FIFO.
`timescale 1ns/1ps
module fc_pair_fifo
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fc_pair_t   push_data,
  input  logic       pop,
  output logic [1:0] count,
  output fc_pair_t   head
);

  fc_pair_t   head_q;
  fc_pair_t   tail_q;
  logic [1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // With one entry left the head goes stale, but out_valid is low then.
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fc_feeder.sv
// Streams N_IN (activation, weight) pairs from two sync-read memories over a
// valid/ready port, one pair per cycle when the consumer keeps up.
`timescale 1ns/1ps
module fc_feeder
  import cnn_pkg::*;
#(
  parameter int N_IN   = N_IN_FC,
  parameter int ACT_W  = cnn_pkg::ACT_W,
  parameter int W_W    = cnn_pkg::W_W,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_addr,
  input  logic [ACT_W-1:0]  act_rdata,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [W_W-1:0]    w_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACT_W-1:0]  out_act,
  output logic [W_W-1:0]    out_w,
  output logic              out_last,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Valid/ready: a pair transfers on any cycle with out_valid && out_ready;
  // while out_valid && !out_ready the pair is held and out_valid stays high.

  fc_feed_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [1:0]        count;
  fc_pair_t          head;
  fc_pair_t          push_data;
  logic              pop;
  logic              rd_en;
  logic              rd_last;
  logic [2:0]        occ;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  // Credit: slots already claimed after this cycle's pop; pop implies count >= 1.
  assign occ       = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_last   = (addr_q == ADDR_W'(N_IN - 1));
  assign push_data = '{act: act_rdata, w: w_rdata, last: inflight_last_q};

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        rd_en = (occ < 3'd2);
        if (rd_en && rd_last) state_d = DRAIN;
      end
      DRAIN:   if (pop && head.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && rd_last;
      if (state_q == IDLE && start) addr_q <= '0;
      else if (rd_en && !rd_last)   addr_q <= addr_q + 1'b1;
    end
  end

  fc_pair_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign act_rd_en = rd_en;
  assign w_rd_en   = rd_en;
  assign act_addr  = addr_q;
  assign w_addr    = addr_q;
  assign out_act   = head.act;
  assign out_w     = head.w;
  assign out_last  = head.last;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fc_feeder.sv
// Bench for fc_feeder: a 4-pair instance for timing/corner cases and a
// full-size instance for long passes, sharing one memory image.
`timescale 1ns/1ps
module tb_fc_feeder;
  import cnn_pkg::*;

  localparam int AW = 12;
  localparam int NS = 4;
  localparam int NB = 3136;
  localparam int PW = 30 + 9 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_v [2];
  logic          start_v [2];
  logic          ready_v [2];
  logic          busy_v [2];
  logic          act_rd_en_v [2];
  logic          w_rd_en_v [2];
  logic          valid_v [2];
  logic          last_v [2];
  logic          done_v [2];
  logic [AW-1:0] act_addr_v [2];
  logic [AW-1:0] w_addr_v [2];
  logic [29:0]   act_rdata_v [2];
  logic [29:0]   out_act_v [2];
  logic [8:0]    w_rdata_v [2];
  logic [8:0]    out_w_v [2];
  logic [1:0]    dbg_v [2];

  fc_feeder #(.N_IN(NS)) dut_small (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]),
    .act_rd_en(act_rd_en_v[0]), .act_addr(act_addr_v[0]), .act_rdata(act_rdata_v[0]),
    .w_rd_en(w_rd_en_v[0]), .w_addr(w_addr_v[0]), .w_rdata(w_rdata_v[0]),
    .out_valid(valid_v[0]), .out_ready(ready_v[0]), .out_act(out_act_v[0]),
    .out_w(out_w_v[0]), .out_last(last_v[0]), .done(done_v[0]), .dbg_state(dbg_v[0])
  );

  fc_feeder #(.N_IN(NB)) dut_big (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]),
    .act_rd_en(act_rd_en_v[1]), .act_addr(act_addr_v[1]), .act_rdata(act_rdata_v[1]),
    .w_rd_en(w_rd_en_v[1]), .w_addr(w_addr_v[1]), .w_rdata(w_rdata_v[1]),
    .out_valid(valid_v[1]), .out_ready(ready_v[1]), .out_act(out_act_v[1]),
    .out_w(out_w_v[1]), .out_last(last_v[1]), .done(done_v[1]), .dbg_state(dbg_v[1])
  );

  // Shared synchronous-read memory image, one read port per instance.
  logic [29:0] act_mem [4096];
  logic [8:0]  w_mem [4096];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (act_rd_en_v[d]) act_rdata_v[d] <= act_mem[act_addr_v[d]];
      if (w_rd_en_v[d])   w_rdata_v[d]   <= w_mem[w_addr_v[d]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input bit ok, input longint got, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, req, cyc);
  endtask

  logic [PW-1:0] exp_q [$];
  int sel = 0;
  int reads = 0;
  int hs = 0;
  int rb = 0;
  int hb = 0;
  int last_hs_cyc = -10;
  int rd_cnt [4096];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic prst = 1'b0;
  logic [PW-1:0] pdata = '0;

  always @(negedge clk) begin
    logic [PW-1:0] got;
    logic [PW-1:0] e;
    got = {out_act_v[sel], out_w_v[sel], last_v[sel]};
    if (act_rd_en_v[sel] || w_rd_en_v[sel]) begin
      check("rd_port_match", act_rd_en_v[sel] == w_rd_en_v[sel] && act_addr_v[sel] == w_addr_v[sel],
            longint'(w_addr_v[sel]), longint'(act_addr_v[sel]));
      if (sel == 1) rd_cnt[act_addr_v[sel]]++;
      reads++;
    end
    if (pv && !pr && !prst)
      check("hold_stable", valid_v[sel] && got == pdata, {valid_v[sel], got}, {1'b1, pdata});
    if (valid_v[sel] && ready_v[sel]) begin
      hs++;
      if (exp_q.size() == 0) check("extra_pair", 1'b0, got, 0);
      else begin
        e = exp_q.pop_front();
        check("pair_data", got == e, got, e);
      end
      if (last_v[sel]) last_hs_cyc = cyc;
    end
    if (act_rd_en_v[sel])
      check("read_lead", (reads - rb) - (hs - hb) <= 2, (reads - rb) - (hs - hb), 2);
    if (done_v[sel])
      check("done_after_last", cyc == last_hs_cyc + 1, cyc, last_hs_cyc + 1);
    pv    = valid_v[sel];
    pr    = ready_v[sel];
    prst  = rst_v[sel];
    pdata = got;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pair k is simply memory entry k, tagged last at k == n-1.
  task automatic load_exp(input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({act_mem[k], w_mem[k], 1'(k == n - 1)});
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for pass cycles 4..13,
  // 3: ready high plus a stray start at cycle 5. off = cycle of done after t0.
  task automatic run_pass(input int d, input int n, input int mode, input int budget, output int off);
    sel = d;
    load_exp(n);
    rb = reads;
    hb = hs;
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    off = -1;
    for (int c = 1; c <= budget; c++) begin
      case (mode)
        1: ready_v[d] = 1'($urandom_range(0, 1));
        2: ready_v[d] = !(c >= 4 && c <= 13);
        3: start_v[d] = (c == 5);
        default: ready_v[d] = 1'b1;
      endcase
      @(negedge clk);
      if (done_v[d]) begin
        off = c;
        break;
      end
      step();
    end
    check("done_seen", off >= 0, off, budget);
    ready_v[d] = 1'b1;
    start_v[d] = 1'b0;
    step();
    @(negedge clk);
    check("busy_low_after_done", !busy_v[d] && !done_v[d], {busy_v[d], done_v[d]}, 0);
    check("all_pairs_out", exp_q.size() == 0, exp_q.size(), 0);
    check("handshake_count", hs - hb == n, hs - hb, n);
    step();
  endtask

  typedef struct {
    logic        busy;
    logic        valid;
    logic        last;
    logic        done;
    logic [29:0] act;
    logic [8:0]  w;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int off;
    int bad;
    int quiet;
    logic [29:0] ta;
    logic [8:0]  tw;

    ta = 30'd10;          tw = 9'd1;
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, ta, tw};
    ta = 30'h3FFF_FFFD;   tw = 9'h100;
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, ta, tw};
    ta = 30'd7;           tw = 9'h0FF;
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, ta, tw};
    ta = 30'h1FFF_FFFF;   tw = 9'd2;
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, ta, tw};
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 9'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 9'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 30'd0, 9'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 9'd0};

    for (int i = 0; i < 4; i++) begin
      act_mem[i] = tbl[i + 2].act;
      w_mem[i]   = tbl[i + 2].w;
    end
    for (int i = 4; i < 4096; i++) begin
      act_mem[i] = 30'($urandom());
      w_mem[i]   = 9'($urandom());
    end
    for (int i = 0; i < 4096; i++) rd_cnt[i] = 0;

    for (int d = 0; d < 2; d++) begin
      rst_v[d]   = 1'b1;
      start_v[d] = 1'b0;
      ready_v[d] = 1'b1;
    end
    repeat (3) step();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_outputs",
            {busy_v[d], act_rd_en_v[d], w_rd_en_v[d], act_addr_v[d], w_addr_v[d], valid_v[d],
             out_act_v[d], out_w_v[d], last_v[d], done_v[d], dbg_v[d]} == '0,
            {busy_v[d], act_rd_en_v[d], act_addr_v[d], valid_v[d], out_act_v[d], out_w_v[d],
             last_v[d], done_v[d]}, 0);
    step();

    // Cycle-exact 4-pair pass against the vector table.
    sel = 0;
    load_exp(NS);
    rb = reads;
    hb = hs;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t%0d_busy", i + 1), busy_v[0] == tbl[i].busy, busy_v[0], tbl[i].busy);
      check($sformatf("t%0d_valid", i + 1), valid_v[0] == tbl[i].valid, valid_v[0], tbl[i].valid);
      check($sformatf("t%0d_done", i + 1), done_v[0] == tbl[i].done, done_v[0], tbl[i].done);
      if (tbl[i].valid) begin
        check($sformatf("t%0d_act", i + 1), out_act_v[0] == tbl[i].act, out_act_v[0], tbl[i].act);
        check($sformatf("t%0d_w", i + 1), out_w_v[0] == tbl[i].w, out_w_v[0], tbl[i].w);
        check($sformatf("t%0d_last", i + 1), last_v[0] == tbl[i].last, last_v[0], tbl[i].last);
      end
      step();
    end
    check("table_pairs_out", exp_q.size() == 0, exp_q.size(), 0);

    // Ten-cycle stall on pair 1 pushes done out by exactly ten cycles.
    run_pass(0, NS, 2, 100, off);
    check("stall_done_cycle", off == 17, off, 17);

    // Stray start mid-pass changes nothing.
    run_pass(0, NS, 3, 100, off);
    check("stray_start_done_cycle", off == 7, off, 7);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy_v[0] || valid_v[0]) quiet++;
      step();
    end
    check("no_second_pass", quiet == 0, quiet, 0);

    // Reset for one cycle while a read is outstanding.
    sel = 0;
    load_exp(NS);
    rb = reads;
    hb = hs;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    step();
    rst_v[0] = 1'b1;
    @(negedge clk);
    check("rst_read_in_flight", act_rd_en_v[0] == 1'b1, act_rd_en_v[0], 1);
    step();
    rst_v[0] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midpass_reset_outputs",
          {busy_v[0], act_rd_en_v[0], w_rd_en_v[0], act_addr_v[0], w_addr_v[0], valid_v[0],
           out_act_v[0], out_w_v[0], last_v[0], done_v[0]} == '0,
          {busy_v[0], act_rd_en_v[0], act_addr_v[0], valid_v[0], out_act_v[0], out_w_v[0],
           last_v[0], done_v[0]}, 0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      if (valid_v[0] || busy_v[0]) quiet++;
    end
    check("no_stale_pair", quiet == 0, quiet, 0);
    step();
    run_pass(0, NS, 0, 100, off);
    check("post_reset_done_cycle", off == 7, off, 7);

    // Full-size pass at full rate.
    run_pass(1, NB, 0, NB + 50, off);
    check("full_done_cycle", off == NB + 3, off, NB + 3);
    bad = 0;
    for (int a = 0; a < 4096; a++)
      if (rd_cnt[a] != ((a < NB) ? 1 : 0)) bad++;
    check("each_addr_read_once", bad == 0, bad, 0);

    // Full-size pass with random back-pressure.
    run_pass(1, NB, 1, 4 * NB, off);
    check("random_done_not_early", off >= NB + 3, off, NB + 3);
    bad = 0;
    for (int a = 0; a < 4096; a++)
      if (rd_cnt[a] != ((a < NB) ? 2 : 0)) bad++;
    check("each_addr_read_once_random", bad == 0, bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
